// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time, and holds the result for decode.
// Define YSYX_22040759_IFU_MISALIGN_EN to make misaligned redirects raise a sticky fetch_err and enter ERR.
module ysyx_22040759_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_q;
  logic [31:0] inst_q;
  logic        kill;
  logic        fetch_err_q;
  logic        redirect_bad;
  logic [63:0] redirect_tgt;

`ifdef YSYX_22040759_IFU_MISALIGN_EN
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_bad = 1'b0;
  assign redirect_tgt = redirect_pc & ~64'h3;
`endif

  // A redirect masks both handshakes combinationally so no wrong-path transfer happens this cycle.
  assign imem_req_valid = (state == REQ) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign id_valid       = (state == HOLD) && !redirect_valid;
  assign id_inst        = (state == HOLD) ? inst_q : NOP_INST;
  assign id_pc          = pc_q;
  assign fetch_err      = fetch_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      kill        <= 1'b0;
      fetch_err_q <= 1'b0;
    end else if (redirect_valid && state != ERR) begin
      pc <= redirect_tgt;
      if (redirect_bad) begin
        fetch_err_q <= 1'b1;
        kill        <= 1'b0;
        state       <= ERR;
      end else if (state == WAIT && !imem_rsp_valid) begin
        // The in-flight response belongs to the old path; drop it when it lands.
        kill <= 1'b1;
      end else begin
        kill  <= 1'b0;
        state <= REQ;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              inst_q <= imem_rsp_data;
              pc_q   <= pc;
              pc     <= pc + 64'd4;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (id_ready) state <= REQ;
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Self-checking bench for ysyx_22040759_ifu: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stage and a latency-programmable memory.
module tb_ysyx_22040759_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef YSYX_22040759_IFU_MISALIGN_EN
  localparam bit MISALIGN_ON = 1'b1;
`else
  localparam bit MISALIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: is a fetch in flight, is it stale, is an instruction held, has it errored.
  bit          m_booted, m_busy, m_drop, m_have, m_err;
  logic [63:0] m_pc, m_pcq;
  logic [31:0] m_inst;

  // Memory: one pending response delivered mem_lat cycles after acceptance.
  bit          mem_pending = 1'b0;
  int          mem_delay   = 0;
  int          mem_lat     = 1;
  logic [31:0] next_data   = 32'h0;

  ysyx_22040759_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_booted && !m_busy && !m_have && !m_err && !redirect_valid;
  endfunction

  task automatic model_reset();
    m_booted = 0; m_busy = 0; m_drop = 0; m_have = 0; m_err = 0;
    m_pc = RESET_PC; m_pcq = RESET_PC; m_inst = NOP_INST;
  endtask

  task automatic check_all();
    checkOutput("req_valid", 64'(imem_req_valid), 64'(exp_req()));
    checkOutput("req_addr",  imem_req_addr, m_pc);
    checkOutput("id_valid",  64'(id_valid), 64'(m_have && !redirect_valid));
    checkOutput("id_inst",   64'(id_inst), 64'(m_have ? m_inst : NOP_INST));
    checkOutput("id_pc",     id_pc, m_pcq);
    checkOutput("fetch_err", 64'(fetch_err), 64'(m_err));
  endtask

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_clock();
    bit hs;
    hs = exp_req() && imem_req_ready;
    if (m_err) return;
    if (redirect_valid) begin
      m_booted = 1;
      m_have   = 0;
      if (MISALIGN_ON && redirect_pc[1:0] != 2'b00) begin
        m_err = 1; m_busy = 0; m_drop = 0; m_pc = redirect_pc;
      end else begin
        m_pc = redirect_pc & ~64'h3;
        if (m_busy) begin
          if (imem_rsp_valid) begin m_busy = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end
    end else if (!m_booted) begin
      m_booted = 1;
    end else if (m_busy) begin
      if (imem_rsp_valid) begin
        m_busy = 0;
        if (m_drop) m_drop = 0;
        else begin
          m_have = 1; m_inst = imem_rsp_data; m_pcq = m_pc; m_pc = m_pc + 64'd4;
        end
      end
    end else if (m_have) begin
      if (id_ready) m_have = 0;
    end
    if (hs) begin
      m_busy = 1; mem_pending = 1; mem_delay = mem_lat;
    end
  endtask

  task automatic applyStimulus(input bit rv, input logic [63:0] rpc, input bit rdy, input bit idr);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    id_ready       = idr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pending) begin
      mem_delay--;
      if (mem_delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = next_data;
        mem_pending    = 0;
      end
    end
    #1;
    check_all();
    model_clock();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_req_addr",  imem_req_addr, RESET_PC);
    checkOutput("rst_id_valid",  64'(id_valid), 64'd0);
    checkOutput("rst_id_inst",   64'(id_inst), 64'(NOP_INST));
    checkOutput("rst_id_pc",     id_pc, RESET_PC);
    checkOutput("rst_fetch_err", 64'(fetch_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    model_clock();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic fetch with 1-cycle memory.
    mem_lat = 1; next_data = 32'h0000_0297;
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t1_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t1_req_addr", imem_req_addr, 64'h8000_0000);
    applyStimulus(0, 64'h0, 1, 1);
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t1_id_valid", 64'(id_valid), 64'd1);
    checkOutput("t1_id_inst", 64'(id_inst), 64'h0000_0297);
    checkOutput("t1_id_pc", id_pc, 64'h8000_0000);
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t1_next_addr", imem_req_addr, 64'h8000_0004);

    // Decode stalls for 5 cycles in HOLD.
    next_data = 32'h00a0_0513;
    applyStimulus(0, 64'h0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 64'h0, 1, 0);
      checkOutput("t2_stall_id_valid", 64'(id_valid), 64'd1);
      checkOutput("t2_stall_id_inst", 64'(id_inst), 64'h00a0_0513);
      checkOutput("t2_stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    applyStimulus(0, 64'h0, 1, 1);
    mem_lat = 4;
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t2_next_addr", imem_req_addr, 64'h8000_0008);

    // Redirect in WAIT, response lands 3 cycles later and must be squashed.
    applyStimulus(1, 64'h8000_0100, 0, 1);
    checkOutput("t3_id_valid_redirect", 64'(id_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 64'h0, 0, 1);
      checkOutput("t3_id_valid_squash", 64'(id_valid), 64'd0);
    end
    mem_lat = 1;
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t3_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t3_req_addr", imem_req_addr, 64'h8000_0100);

    // Redirect and response in the same WAIT cycle.
    applyStimulus(1, 64'h8000_0200, 1, 1);
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t4_req_addr", imem_req_addr, 64'h8000_0200);
    checkOutput("t4_id_valid", 64'(id_valid), 64'd0);

    // Redirect while an instruction is held.
    next_data = 32'h0010_0073;
    applyStimulus(0, 64'h0, 1, 1);
    applyStimulus(1, 64'h8000_0300, 1, 1);
    checkOutput("t5_id_valid_masked", 64'(id_valid), 64'd0);
    applyStimulus(0, 64'h0, 0, 1);
    checkOutput("t5_req_addr", imem_req_addr, 64'h8000_0300);
    checkOutput("t5_req_valid", 64'(imem_req_valid), 64'd1);

    // PC wraps modulo 2^64.
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
    checkOutput("t6_req_masked", 64'(imem_req_valid), 64'd0);
    applyStimulus(0, 64'h0, 1, 1);
    applyStimulus(0, 64'h0, 1, 1);
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t6_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(0, 64'h0, 0, 1);
    checkOutput("t6_wrap_addr", imem_req_addr, 64'h0);

    // Misaligned redirect.
    applyStimulus(1, 64'h8000_0102, 0, 1);
    applyStimulus(0, 64'h0, 1, 1);
`ifdef YSYX_22040759_IFU_MISALIGN_EN
    checkOutput("t7_fetch_err", 64'(fetch_err), 64'd1);
    checkOutput("t7_no_req", 64'(imem_req_valid), 64'd0);
`else
    checkOutput("t7_aligned_addr", imem_req_addr, 64'h8000_0100);
    checkOutput("t7_req_valid", 64'(imem_req_valid), 64'd1);
`endif
    applyStimulus(1, 64'h8000_0400, 1, 1);
    applyStimulus(0, 64'h0, 1, 1);
`ifdef YSYX_22040759_IFU_MISALIGN_EN
    checkOutput("t7_err_sticky", 64'(fetch_err), 64'd1);
    checkOutput("t7_err_no_req", 64'(imem_req_valid), 64'd0);
`else
    checkOutput("t7_redirect_addr", imem_req_addr, 64'h8000_0400);
    checkOutput("t7_no_err", 64'(fetch_err), 64'd0);
`endif

    // Reset mid-WAIT; the late response must be ignored.
    do_reset();
    mem_lat = 3;
    applyStimulus(0, 64'h0, 1, 1);
    applyStimulus(0, 64'h0, 0, 1);
    do_reset();
    mem_lat = 1;
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(0, 64'h0, 0, 1);
    checkOutput("t8_late_rsp_id_valid", 64'(id_valid), 64'd0);
    applyStimulus(0, 64'h0, 1, 1);
    checkOutput("t8_req_addr", imem_req_addr, RESET_PC);
    checkOutput("t8_id_valid", 64'(id_valid), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      if (MISALIGN_ON) rpc[1:0] = 2'b00;
      mem_lat   = $urandom_range(1, 4);
      next_data = $urandom;
      applyStimulus($urandom_range(0, 7) == 0, rpc,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
